// File: rtl/input_vc_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : input_vc_buffer_if                                           |
// | Description : Link, switch-allocation and crossbar signals of one input    |
// |               VC buffer. The master drives the link side; the slave is the |
// |               buffer.                                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface input_vc_buffer_if #(
  parameter int NUM_VCS = 4,
  parameter int FLIT_W  = 32
);
  localparam int VC_W = $clog2(NUM_VCS);

  logic               in_valid;
  logic [VC_W-1:0]    in_vc;
  logic               in_head;
  logic               in_tail;
  logic [FLIT_W-1:0]  in_flit;
  logic [NUM_VCS-1:0] ds_credit;
  logic [NUM_VCS-1:0] sa_req;
  logic [NUM_VCS-1:0] sa_grant;
  logic               out_valid;
  logic [VC_W-1:0]    out_vc;
  logic               out_head;
  logic               out_tail;
  logic [FLIT_W-1:0]  out_flit;
  logic               credit_valid;
  logic [VC_W-1:0]    credit_vc;
  logic [2:0]         err;

  modport master (
    output in_valid, in_vc, in_head, in_tail, in_flit, ds_credit, sa_grant,
    input  sa_req, out_valid, out_vc, out_head, out_tail, out_flit,
           credit_valid, credit_vc, err
  );

  modport slave (
    input  in_valid, in_vc, in_head, in_tail, in_flit, ds_credit, sa_grant,
    output sa_req, out_valid, out_vc, out_head, out_tail, out_flit,
           credit_valid, credit_vc, err
  );
endinterface
`default_nettype wire

// File: rtl/input_vc_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : input_vc_buffer                                              |
// | Description : Per-input-port VC flit buffer: one circular FIFO per VC, SA  |
// |               requests, grant-driven pop with credit return, framing check.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module input_vc_buffer #(
  parameter int NUM_VCS   = 4,
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 32
) (
  input  logic              clk,
  input  logic              arst,
  input_vc_buffer_if.slave  bus
);
  localparam int VC_W    = $clog2(NUM_VCS);
  localparam int PTR_W   = $clog2(BUF_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = FLIT_W + 2;

  typedef enum logic [0:0] {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_t;

  logic [NUM_VCS-1:0] w_empty;
  logic [NUM_VCS-1:0] w_full;
  logic [NUM_VCS-1:0] w_req;
  logic [NUM_VCS-1:0] w_push;
  logic [NUM_VCS-1:0] w_pop;
  logic [NUM_VCS-1:0] w_proto_err;
  logic [ENTRY_W-1:0] w_head_entry [NUM_VCS];
  logic               w_grant_onehot;
  logic               w_grant_ok;
  logic               w_grant_err;
  logic               w_overflow;
  logic [VC_W-1:0]    w_pop_vc;
  logic [ENTRY_W-1:0] w_pop_entry;

  logic               r_out_valid;
  logic [VC_W-1:0]    r_out_vc;
  logic               r_out_head;
  logic               r_out_tail;
  logic [FLIT_W-1:0]  r_out_flit;
  logic [2:0]         r_err;

  // A grant only pops when it is one-hot and lands on a requesting VC.
  assign w_grant_onehot = (bus.sa_grant != '0) &&
                          ((bus.sa_grant & (bus.sa_grant - NUM_VCS'(1))) == '0);
  assign w_grant_ok     = w_grant_onehot && |(bus.sa_grant & w_req);
  assign w_grant_err    = |bus.sa_grant && !w_grant_ok;
  assign w_pop          = w_grant_ok ? bus.sa_grant : '0;
  assign w_overflow     = bus.in_valid && w_full[bus.in_vc] && !w_pop[bus.in_vc];

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_mem [BUF_DEPTH];
    vc_state_t          r_state;
    vc_state_t          w_state_nxt;
    logic               w_push_hit;
    logic               w_proto_err_vc;

    assign w_empty[v]      = (r_count == '0);
    assign w_full[v]       = (r_count == CNT_W'(BUF_DEPTH));
    assign w_req[v]        = !w_empty[v] && bus.ds_credit[v];
    assign w_push_hit      = bus.in_valid && (bus.in_vc == VC_W'(v));
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push[v]       = w_push_hit && (!w_full[v] || w_pop[v]);
    assign w_head_entry[v] = r_mem[r_rd_ptr];
    assign w_proto_err[v]  = w_proto_err_vc;

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[v]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop[v])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push[v], w_pop[v]})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[v]) r_mem[r_wr_ptr] <= {bus.in_head, bus.in_tail, bus.in_flit};
    end

    always_ff @(posedge clk or posedge arst) begin
      if (arst) r_state <= VC_IDLE;
      else      r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_proto_err_vc = 1'b0;
      if (w_push[v]) begin
        w_proto_err_vc = bus.in_head ? (r_state == VC_ACTIVE) : (r_state == VC_IDLE);
        if (bus.in_tail)      w_state_nxt = VC_IDLE;
        else if (bus.in_head) w_state_nxt = VC_ACTIVE;
      end
    end
  end

  always_comb begin
    w_pop_vc = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (w_pop[i]) w_pop_vc = VC_W'(i);
    end
  end

  assign w_pop_entry = w_head_entry[w_pop_vc];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out_valid <= 1'b0;
      r_out_vc    <= '0;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_flit  <= '0;
      r_err       <= '0;
    end else begin
      r_out_valid <= |w_pop;
      if (|w_pop) begin
        r_out_vc   <= w_pop_vc;
        r_out_head <= w_pop_entry[ENTRY_W-1];
        r_out_tail <= w_pop_entry[ENTRY_W-2];
        r_out_flit <= w_pop_entry[FLIT_W-1:0];
      end
      r_err <= r_err | {w_grant_err, |w_proto_err, w_overflow};
    end
  end

  // The credit leaves together with the flit it belongs to.
  assign bus.sa_req       = w_req;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_vc       = r_out_vc;
  assign bus.out_head     = r_out_head;
  assign bus.out_tail     = r_out_tail;
  assign bus.out_flit     = r_out_flit;
  assign bus.credit_valid = r_out_valid;
  assign bus.credit_vc    = r_out_vc;
  assign bus.err          = r_err;
endmodule
`default_nettype wire

// File: tb/tb_input_vc_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_input_vc_buffer                                           |
// | Description : Directed scenarios plus random traffic against a queue model.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_input_vc_buffer;
  localparam int NV = 4;
  localparam int D  = 4;
  localparam int FW = 32;
  localparam int VW = 2;

  typedef struct packed {
    logic          head;
    logic          tail;
    logic [FW-1:0] flit;
  } flit_t;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  input_vc_buffer_if #(.NUM_VCS(NV), .FLIT_W(FW)) bus ();

  input_vc_buffer #(.NUM_VCS(NV), .BUF_DEPTH(D), .FLIT_W(FW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  flit_t      mq [NV][$];
  bit         m_active [NV];
  logic [2:0] m_err;
  bit         e_ov;
  int         e_vc;
  flit_t      e_f;
  logic [NV-1:0] obs_req;
  logic [NV-1:0] exp_req;

  function automatic logic [NV-1:0] model_req(input logic [NV-1:0] cr);
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = (mq[v].size() != 0) && cr[v];
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      m_active[v] = 1'b0;
    end
    m_err = 3'b000;
    e_ov  = 1'b0;
  endtask

  // One clock of the reference: pop from the pre-edge contents, then append.
  task automatic model_step(input bit pv, input int vc, input bit h, input bit t,
                            input logic [FW-1:0] f, input logic [NV-1:0] g,
                            input logic [NV-1:0] cr);
    logic [NV-1:0] r;
    r    = model_req(cr);
    e_ov = 1'b0;
    if (g != '0) begin
      if ($countones(g) == 1 && (g & r) != '0) begin
        for (int v = 0; v < NV; v++) begin
          if (g[v]) begin
            e_f  = mq[v].pop_front();
            e_vc = v;
            e_ov = 1'b1;
          end
        end
      end else begin
        m_err[2] = 1'b1;
      end
    end
    if (pv) begin
      if (mq[vc].size() == D) begin
        m_err[0] = 1'b1;
      end else begin
        if (h ? m_active[vc] : !m_active[vc]) m_err[1] = 1'b1;
        if (t)      m_active[vc] = 1'b0;
        else if (h) m_active[vc] = 1'b1;
        mq[vc].push_back('{head: h, tail: t, flit: f});
      end
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input bit pv, input int vc, input bit h, input bit t,
                       input logic [FW-1:0] f, input logic [NV-1:0] g,
                       input logic [NV-1:0] cr);
    bus.in_valid  = pv;
    bus.in_vc     = VW'(vc);
    bus.in_head   = h;
    bus.in_tail   = t;
    bus.in_flit   = f;
    bus.sa_grant  = g;
    bus.ds_credit = cr;
    #1;
    obs_req = bus.sa_req;
    exp_req = model_req(cr);
    model_step(pv, vc, h, t, f, g, cr);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sa_grant = '0;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_vc     = '0;
    bus.in_head   = 1'b0;
    bus.in_tail   = 1'b0;
    bus.in_flit   = '0;
    bus.sa_grant  = '0;
    bus.ds_credit = '1;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, 32'h100 + i, '0, '1);
    drive(0, 0, 0, 0, '0, 4'b0010, '1);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_out_valid: got %b expected 1", bus.out_valid);
    end
    #2 arst = 1'b1;
    #1;
    n_cmp++;
    if (bus.sa_req !== 4'b0000) begin
      n_fail++; $display("FAIL reset_sa_req: got %b expected 0000", bus.sa_req);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_credit_valid: got %b expected 0", bus.credit_valid);
    end
    n_cmp++;
    if (bus.err !== 3'b000) begin
      n_fail++; $display("FAIL reset_err: got %b expected 000", bus.err);
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, '0, '0, '1);
    n_cmp++;
    if (obs_req !== 4'b0000) begin
      n_fail++; $display("FAIL reset_discard: sa_req got %b expected 0000", obs_req);
    end
  endtask

  task automatic test_single_flit();
    do_reset();
    drive(1, 2, 1, 1, 32'hDEADBEEF, '0, 4'hF);
    drive(0, 0, 0, 0, '0, 4'b0100, 4'hF);
    n_cmp++;
    if (obs_req !== 4'b0100) begin
      n_fail++; $display("FAIL single_sa_req: got %b expected 0100", obs_req);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_vc !== 2'd2 || bus.out_flit !== 32'hDEADBEEF ||
        bus.out_head !== 1'b1 || bus.out_tail !== 1'b1) begin
      n_fail++;
      $display("FAIL single_out: got v=%b vc=%0d flit=%h h=%b t=%b expected v=1 vc=2 flit=deadbeef h=1 t=1",
               bus.out_valid, bus.out_vc, bus.out_flit, bus.out_head, bus.out_tail);
    end
    n_cmp++;
    if (bus.credit_valid !== 1'b1 || bus.credit_vc !== 2'd2) begin
      n_fail++; $display("FAIL single_credit: got v=%b vc=%0d expected v=1 vc=2", bus.credit_valid, bus.credit_vc);
    end
    drive(0, 0, 0, 0, '0, '0, 4'hF);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got out_valid=%b credit_valid=%b expected 0 0", bus.out_valid, bus.credit_valid);
    end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, FW'(i), '0, '1);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, '0, 4'b0001, '1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== FW'(k)) begin
        n_fail++; $display("FAIL wrap_pop%0d: got v=%b flit=%0h expected v=1 flit=%0h", k, bus.out_valid, bus.out_flit, k);
      end
    end
    drive(1, 0, 1, 1, 32'd4, '0, '1);
    drive(1, 0, 1, 1, 32'd5, '0, '1);
    for (int k = 2; k < 6; k++) begin
      drive(0, 0, 0, 0, '0, 4'b0001, '1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== FW'(k)) begin
        n_fail++; $display("FAIL wrap_pop%0d: got v=%b flit=%0h expected v=1 flit=%0h", k, bus.out_valid, bus.out_flit, k);
      end
    end
    n_cmp++;
    if (bus.err !== 3'b000) begin
      n_fail++; $display("FAIL wrap_err: got %b expected 000", bus.err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 3, 1, 1, 32'h30 + i, '0, '1);
    n_cmp++;
    if (bus.err !== 3'b001) begin
      n_fail++; $display("FAIL overflow_err: got %b expected 001", bus.err);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, '0, 4'b1000, '1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'h30 + k || bus.out_vc !== 2'd3) begin
        n_fail++; $display("FAIL overflow_drain%0d: got v=%b vc=%0d flit=%h expected v=1 vc=3 flit=%h",
                           k, bus.out_valid, bus.out_vc, bus.out_flit, 32'h30 + k);
      end
    end
    drive(0, 0, 0, 0, '0, '0, '1);
    n_cmp++;
    if (obs_req !== 4'b0000) begin
      n_fail++; $display("FAIL overflow_dropped: sa_req got %b expected 0000", obs_req);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 2, 1, 1, 32'h20 + i, '0, '1);
    drive(1, 2, 1, 1, 32'h24, 4'b0100, '1);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'h20 || bus.err !== 3'b000) begin
      n_fail++; $display("FAIL b2b_full_pushpop: got v=%b flit=%h err=%b expected v=1 flit=20 err=000",
                         bus.out_valid, bus.out_flit, bus.err);
    end
    for (int k = 1; k < 5; k++) begin
      drive(0, 0, 0, 0, '0, 4'b0100, '1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'h20 + k) begin
        n_fail++; $display("FAIL b2b_drain%0d: got v=%b flit=%h expected v=1 flit=%h", k, bus.out_valid, bus.out_flit, 32'h20 + k);
      end
    end
  endtask

  task automatic test_credit_gating();
    do_reset();
    drive(1, 1, 1, 1, 32'h11, '0, 4'hF);
    drive(0, 0, 0, 0, '0, '0, 4'b1101);
    n_cmp++;
    if (obs_req[1] !== 1'b0) begin
      n_fail++; $display("FAIL credit_gated: sa_req[1] got %b expected 0", obs_req[1]);
    end
    drive(0, 0, 0, 0, '0, 4'b0010, 4'hF);
    n_cmp++;
    if (obs_req[1] !== 1'b1) begin
      n_fail++; $display("FAIL credit_open: sa_req[1] got %b expected 1", obs_req[1]);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'h11 || bus.credit_vc !== 2'd1) begin
      n_fail++; $display("FAIL credit_pop: got v=%b flit=%h cvc=%0d expected v=1 flit=11 cvc=1",
                         bus.out_valid, bus.out_flit, bus.credit_vc);
    end
  endtask

  task automatic test_errors();
    do_reset();
    drive(1, 0, 1, 1, 32'hA0, '0, 4'hF);
    drive(0, 0, 0, 0, '0, 4'b0011, 4'hF);
    n_cmp++;
    if (bus.err !== 3'b100 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_grant: got err=%b out_valid=%b expected err=100 out_valid=0", bus.err, bus.out_valid);
    end
    drive(1, 0, 0, 0, 32'hB0, '0, 4'hF);
    n_cmp++;
    if (bus.err !== 3'b110) begin
      n_fail++; $display("FAIL err_proto: got %b expected 110", bus.err);
    end
    drive(0, 0, 0, 0, '0, 4'b0001, 4'hF);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'hA0) begin
      n_fail++; $display("FAIL err_nopop: got v=%b flit=%h expected v=1 flit=a0", bus.out_valid, bus.out_flit);
    end
    drive(0, 0, 0, 0, '0, 4'b0001, 4'hF);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'hB0 || bus.out_head !== 1'b0 || bus.out_tail !== 1'b0) begin
      n_fail++; $display("FAIL err_body_stored: got v=%b flit=%h h=%b t=%b expected v=1 flit=b0 h=0 t=0",
                         bus.out_valid, bus.out_flit, bus.out_head, bus.out_tail);
    end
  endtask

  task automatic test_random();
    logic [NV-1:0] cr;
    logic [NV-1:0] r;
    logic [NV-1:0] g;
    int vc;
    int pick;
    int sel;
    bit pv;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cr   = NV'($urandom);
      vc   = $urandom_range(0, NV - 1);
      pv   = ($urandom_range(0, 1) == 1) && (mq[vc].size() < D);
      r    = model_req(cr);
      g    = '0;
      sel  = $urandom_range(0, 9);
      if (sel < 7 && r != '0) begin
        do pick = $urandom_range(0, NV - 1); while (!r[pick]);
        g[pick] = 1'b1;
      end else if (sel == 9) begin
        g = NV'($urandom);
      end
      drive(pv, vc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, g, cr);
      n_cmp++;
      if (obs_req !== exp_req) begin
        n_fail++; $display("FAIL rand_sa_req[%0d]: got %b expected %b", n, obs_req, exp_req);
      end
      n_cmp++;
      if (bus.out_valid !== e_ov || bus.credit_valid !== e_ov) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got out=%b credit=%b expected %b", n, bus.out_valid, bus.credit_valid, e_ov);
      end else if (e_ov) begin
        n_cmp++;
        if (bus.out_vc !== VW'(e_vc) || bus.credit_vc !== VW'(e_vc) || bus.out_flit !== e_f.flit ||
            bus.out_head !== e_f.head || bus.out_tail !== e_f.tail) begin
          n_fail++;
          $display("FAIL rand_out[%0d]: got vc=%0d cvc=%0d flit=%h h=%b t=%b expected vc=%0d flit=%h h=%b t=%b",
                   n, bus.out_vc, bus.credit_vc, bus.out_flit, bus.out_head, bus.out_tail,
                   e_vc, e_f.flit, e_f.head, e_f.tail);
        end
      end
      n_cmp++;
      if (bus.err !== m_err) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", n, bus.err, m_err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_flit();
    test_fill_wrap();
    test_overflow();
    test_back_to_back();
    test_credit_gating();
    test_errors();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
